fb_pixel_writer: RTL

//  Consumer end of the DrawLine pixel stream: accepts (X,Y) coordinates from the line

---
 rtl/fb_pixel_writer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fb_pixel_writer.sv
// Pixel sink for the DrawLine stream: buffers (X,Y) coordinates, clips them to the screen
// and commits each on-screen pixel into a 1-bpp byte-wide framebuffer by read-modify-write.
module fb_pixel_writer #(
    parameter int H_RES      = 160,
    parameter int V_RES      = 120,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              EN,
    input  logic [7:0]        X_In,
    input  logic [7:0]        Y_In,
    input  logic              COLOR,
    input  logic              LAST,
    input  logic              VALID,
    output logic              READY,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_RD_EN,
    input  logic [7:0]        MEM_RD_DATA,
    output logic              MEM_WR_EN,
    output logic [7:0]        MEM_WR_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic [7:0]        CLIP_CNT
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef struct packed {
        logic       last;
        logic       color;
        logic [7:0] y;
        logic [7:0] x;
    } pix_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLIP,
        S_WAIT,
        S_WRITE
    } state_t;

    state_t state, state_nxt;

    pix_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             live;

    pix_t             head;
    logic [14:0]      head_idx;
    logic             head_on_screen;

    logic             work_color;
    logic             work_last;
    logic             work_clip;
    logic [2:0]       bit_q;
    logic [7:0]       byte_q;
    logic [7:0]       bit_mask;
    logic             clip_drop;

    // READY is held low for the first edge after reset release so it reads 0 throughout reset
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) live <= 1'b0;
        else          live <= 1'b1;
    end

    assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign READY      = live & EN & ~fifo_full;
    assign push       = VALID & READY;

    always_ff @(posedge ACLK) begin
        if (push) fifo_mem[wr_ptr] <= '{last: LAST, color: COLOR, y: Y_In, x: X_In};
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Linear index only matters for on-screen pixels, so 15-bit truncation is harmless
    assign head           = fifo_mem[rd_ptr];
    assign head_idx       = 15'({7'b0, head.y} * 15'(H_RES)) + {7'b0, head.x};
    assign head_on_screen = ({24'b0, head.x} < 32'(H_RES)) && ({24'b0, head.y} < 32'(V_RES));

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        MEM_RD_EN = 1'b0;
        MEM_WR_EN = 1'b0;
        DONE      = 1'b0;
        clip_drop = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = S_CLIP;
                end
            end
            S_CLIP: begin
                if (work_clip) begin
                    clip_drop = 1'b1;
                    DONE      = work_last;
                    state_nxt = S_IDLE;
                end else begin
                    MEM_RD_EN = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: state_nxt = S_WRITE;
            S_WRITE: begin
                MEM_WR_EN = 1'b1;
                DONE      = work_last;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // MEM_ADDR is loaded at pop time so it is already valid during CLIP; clipped pixels leave it untouched
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            work_color <= 1'b0;
            work_last  <= 1'b0;
            work_clip  <= 1'b0;
            bit_q      <= '0;
            byte_q     <= '0;
            MEM_ADDR   <= '0;
            CLIP_CNT   <= '0;
        end else begin
            if (pop) begin
                work_color <= head.color;
                work_last  <= head.last;
                work_clip  <= ~head_on_screen;
                bit_q      <= head_idx[2:0];
                if (head_on_screen) MEM_ADDR <= ADDR_W'(head_idx[14:3]);
            end
            if (state == S_WAIT) byte_q <= MEM_RD_DATA;
            if (clip_drop && (CLIP_CNT != '1)) CLIP_CNT <= CLIP_CNT + 1'b1;
        end
    end

    assign bit_mask = 8'b1 << bit_q;

    always_comb begin
        MEM_WR_DATA = '0;
        if (state == S_WRITE) MEM_WR_DATA = work_color ? (byte_q | bit_mask) : (byte_q & ~bit_mask);
    end

    assign BUSY = ~fifo_empty | (state != S_IDLE);

endmodule
